multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for the state register.
REQ-004 reset  in  1  asynchronous, active-high; forces state to FETCH.
REQ-005 op  in  7  opcode from the instruction register.
REQ-006 funct3  in  3  instruction bits 14:12.
REQ-007 funct7  in  1  instruction bit 30.
REQ-008 Zero  in  1  ALU zero flag.
REQ-009 PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  datapath write strobes.
REQ-010 AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
REQ-011 ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-013 ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-014 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 state  out  4  current state code, for debug.

Function
REQ-017 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
REQ-018 Transitions: FETCH->DECODE. DECODE goes by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op->FETCH with no writes.
REQ-019 Further transitions: MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECR, EXECI and JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-020 Codes 11-15 are illegal and go to FETCH on the next edge; all outputs are 0 while in an illegal code.
REQ-021 Outputs are Moore, decoded from state only, except ImmSrc, ALUControl and PCWrite.
REQ-022 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-025 MEMREAD: ResultSrc=00, AdrSrc=1.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1.
REQ-027 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-028 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-029 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-030 ALUWB: ResultSrc=00, RegWrite=1.
REQ-031 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-032 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-033 Any output field not listed for a state is 0.
REQ-034 PCWrite = PCUpdate | (Branch & Zero); this is combinational, and Zero is sampled in BEQ.
REQ-035 ImmSrc is decoded combinationally from op: lw/I-ALU 00, sw 01, beq 10, jal 11; any other op gives 00.
REQ-036 ALUControl comes from ALUOp, funct3, funct7 and op: ALUOp 00 gives add, 01 gives sub, 10 gives decode by funct3.
REQ-037 Under ALUOp 10, funct3=000 gives sub only if op[5]&funct7, else add.
REQ-038 Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, unknown op 2.

Reset
REQ-039 While reset=1: state=FETCH, and PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
REQ-040 Other outputs show FETCH values while reset=1.
REQ-041 Reset asserted mid-instruction aborts it immediately with no further strobes.
REQ-042 The first edge after reset deasserts executes FETCH.

Structure
REQ-043 A shared include file defines the state codes, opcode constants, ALUOp codes and ALUControl codes.
REQ-044 The existing alu_decoder is instantiated as the single sub-module for ALUControl.
REQ-045 The state register and next-state/output logic stay local to this module.

Verification
REQ-046 Reset held 3 cycles, then released with op=0000011 (lw) -> state 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-047 op=0100011 (sw) -> states 0,1,2,5,0; MemWrite=1 only in state 5, with AdrSrc=1 and ImmSrc=01.
REQ-048 op=1100011 (beq) with Zero=1 in BEQ -> PCWrite=1 and ALUControl=001. Same with Zero=0 -> PCWrite=0. Both return to FETCH.
REQ-049 op=0110011, funct3=000, funct7=1 -> in EXECR ALUControl=001; with funct3=111 -> 010; then ALUWB with RegWrite=1.
REQ-050 op=1101111 (jal) -> states 0,1,10,8,0; PCWrite=1 in JAL; ImmSrc=11.
REQ-051 op=1111111 -> states 0,1,0 with no strobes. Reset asserted in state 3 -> state=0 asynchronously and all strobes 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: state codes,
// opcodes, ALUOp and ALUControl codes, plus the immediate-format decode.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } statetype_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from ALUOp and the instruction's funct fields.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7 only selects sub for register-register ops, never for addi
          3'b000:  alucontrol = (op5 & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore datapath selects per state, with
// combinational ImmSrc, ALUControl and PCWrite.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  statetype_t cur;
  logic       pcupdate, branch, irw, mw, rw, legal;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH: cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_RTYPE:     cur <= S_EXECR;
            OP_IALU:      cur <= S_EXECI;
            OP_BEQ:       cur <= S_BEQ;
            OP_JAL:       cur <= S_JAL;
            default:      cur <= S_FETCH;
          endcase
        end
        S_MEMADR:                  cur <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:                 cur <= S_MEMWB;
        S_EXECR, S_EXECI, S_JAL:   cur <= S_ALUWB;
        default:                   cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    legal     = 1'b1;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = ALUOP_ADD;
    case (cur)
      S_FETCH: begin
        irw       = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    rw = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      default:    legal = 1'b0;
    endcase
  end

  // Strobes are suppressed for the whole reset pulse, not just at the edge
  assign PCWrite  = (pcupdate | (branch & Zero)) & ~reset;
  assign IRWrite  = irw & ~reset;
  assign MemWrite = mw & ~reset;
  assign RegWrite = rw & ~reset;
  assign ImmSrc   = legal ? imm_decode(op) : 2'b00;
  assign state    = cur;

  alu_decoder u_alu_decoder (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7     (funct7),
    .aluop      (aluop),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .state      (state)
  );

  // {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  logic [19:0] act;
  assign act = {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  logic [19:0] exp_q[$];
  string       nm_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [19:0] mon_e;
  string       mon_nm;

  function automatic logic [19:0] v(input logic [3:0] st, input logic pcw, input logic irw,
                                    input logic mw, input logic rw, input logic adr,
                                    input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] imm,
                                    input logic [2:0] alc);
    return {st, pcw, irw, mw, rw, adr, rs, sa, sb, imm, alc};
  endfunction

  function automatic logic [19:0] sRst(input logic [1:0] imm);
    return v(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sF(input logic [1:0] imm);
    return v(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sD(input logic [1:0] imm);
    return v(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sMA(input logic [1:0] imm);
    return v(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sMR(input logic [1:0] imm);
    return v(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sMWB(input logic [1:0] imm);
    return v(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sMW(input logic [1:0] imm);
    return v(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sER(input logic [2:0] alc);
    return v(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alc);
  endfunction
  function automatic logic [19:0] sEI(input logic [2:0] alc);
    return v(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alc);
  endfunction
  function automatic logic [19:0] sWB(input logic [1:0] imm);
    return v(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic logic [19:0] sB(input logic pcw);
    return v(4'd9, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
  endfunction
  function automatic logic [19:0] sJ();
    return v(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
  endfunction

  // Called at posedge+1: queue what this cycle must show, then move to the next cycle
  task automatic cyc(input logic [19:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o;
    funct3 = f3;
    funct7 = f7;
    Zero = z;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      n_chk++;
      if (act === mon_e) n_pass++;
      else $display("FAIL %s: got %h expected %h (state %0d)", mon_nm, act, mon_e, state);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    repeat (3) cyc(sRst(2'b00), "reset_hold");
    reset = 1'b0;

    cyc(sF(2'b00), "lw_fetch");
    cyc(sD(2'b00), "lw_decode");
    cyc(sMA(2'b00), "lw_memadr");
    cyc(sMR(2'b00), "lw_memread");
    cyc(sMWB(2'b00), "lw_memwb");

    setin(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc(sF(2'b01), "sw_fetch");
    cyc(sD(2'b01), "sw_decode");
    cyc(sMA(2'b01), "sw_memadr");
    cyc(sMW(2'b01), "sw_memwrite");

    setin(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc(sF(2'b10), "beq_z1_fetch");
    cyc(sD(2'b10), "beq_z1_decode");
    cyc(sB(1'b1), "beq_z1_branch");
    setin(7'b1100011, 3'b000, 1'b0, 1'b0);
    cyc(sF(2'b10), "beq_z0_fetch");
    cyc(sD(2'b10), "beq_z0_decode");
    cyc(sB(1'b0), "beq_z0_branch");

    setin(7'b0110011, 3'b000, 1'b1, 1'b1);
    cyc(sF(2'b00), "sub_fetch");
    cyc(sD(2'b00), "sub_decode");
    cyc(sER(3'b001), "sub_execr");
    cyc(sWB(2'b00), "sub_aluwb");
    setin(7'b0110011, 3'b111, 1'b0, 1'b0);
    cyc(sF(2'b00), "and_fetch");
    cyc(sD(2'b00), "and_decode");
    cyc(sER(3'b010), "and_execr");
    cyc(sWB(2'b00), "and_aluwb");

    setin(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc(sF(2'b00), "addi_fetch");
    cyc(sD(2'b00), "addi_decode");
    cyc(sEI(3'b000), "addi_execi");
    cyc(sWB(2'b00), "addi_aluwb");
    setin(7'b0010011, 3'b010, 1'b0, 1'b0);
    cyc(sF(2'b00), "slti_fetch");
    cyc(sD(2'b00), "slti_decode");
    cyc(sEI(3'b101), "slti_execi");
    cyc(sWB(2'b00), "slti_aluwb");

    setin(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc(sF(2'b11), "jal_fetch");
    cyc(sD(2'b11), "jal_decode");
    cyc(sJ(), "jal_jal");
    cyc(sWB(2'b11), "jal_aluwb");

    setin(7'b1111111, 3'b000, 1'b0, 1'b1);
    cyc(sF(2'b00), "bad_fetch");
    cyc(sD(2'b00), "bad_decode");

    setin(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc(sF(2'b00), "lw2_fetch");
    cyc(sD(2'b00), "lw2_decode");
    cyc(sMA(2'b00), "lw2_memadr");
    // Now in MEMREAD; the reset must take hold before the next clock edge
    reset = 1'b1;
    cyc(sRst(2'b00), "async_rst");
    cyc(sRst(2'b00), "rst_hold2");
    reset = 1'b0;

    setin(7'b0110011, 3'b110, 1'b0, 1'b0);
    cyc(sF(2'b00), "or_fetch");
    cyc(sD(2'b00), "or_decode");
    cyc(sER(3'b011), "or_execr");
    cyc(sWB(2'b00), "or_aluwb");
    cyc(sF(2'b00), "end_fetch");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
